// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the pipeline NOP, the default reset PC and the fetch FSM encoding.
package if_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry in-order buffer of fetched {pc, instr} pairs.
// Flush wins over push/pop; push and pop in the same cycle both take effect.
module fetch_buffer
  import if_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t [1:0] slots_q, slots_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop, wr_ptr;

  // When full, the write slot aliases the head, which is legal only alongside a pop.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_ptr   = rd_ptr_q ^ count_q[0];
    slots_d  = slots_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) slots_d[wr_ptr] = push_entry;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  assign head_entry = slots_q[rd_ptr_q];
  assign full       = (count_q == 2'd2);
  assign empty      = (count_q == 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues word fetches under a two-slot credit, buffers
// in-order responses for IF/ID, and drains stale responses after a redirect.
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTRUCTION = DEFAULT_NOP_INSTRUCTION
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]  redirect_target;
  logic [2:0]   credit_used;
  logic         req_fire, resp_take, buf_pop;
  logic         buf_full, buf_empty;
  logic [1:0]   buf_count;
  fetch_entry_t push_entry, head_entry;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign credit_used     = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid  = !rst && !redirect_valid && (state_q == ST_RUN)
                           && !buf_full && (credit_used < 3'd2);
  assign imem_addr       = fetch_pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign resp_take       = imem_resp_valid && (state_q == ST_RUN) && !redirect_valid;
  assign push_entry      = '{pc: resp_pc_q, instr: imem_resp_data};

  assign if_valid       = !rst && !buf_empty;
  assign buf_pop        = if_valid && id_ready;
  assign if_pc          = if_valid ? head_entry.pc : 32'h0;
  assign if_pc_plus_4   = if_valid ? head_entry.pc + 32'd4 : 32'h0;
  assign if_instruction = if_valid ? head_entry.instr : NOP_INSTRUCTION;

  // A response in the redirect cycle is already gone, so it never joins the drop count.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_target;
      resp_pc_d     = redirect_target;
      outstanding_d = 2'd0;
      if (state_q == ST_RUN)
        drop_cnt_d = outstanding_q - {1'b0, imem_resp_valid && (outstanding_q != 2'd0)};
      else
        drop_cnt_d = drop_cnt_q - {1'b0, imem_resp_valid && (drop_cnt_q != 2'd0)};
      state_d = (drop_cnt_d != 2'd0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      if (imem_resp_valid && (drop_cnt_q != 2'd0)) drop_cnt_d = drop_cnt_q - 2'd1;
      if (drop_cnt_d == 2'd0) state_d = ST_RUN;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_take) resp_pc_d  = resp_pc_q + 32'd4;
      outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, resp_take};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (resp_take),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .head_entry (head_entry),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based memory and stream model.
// The model tracks in-flight requests, stale responses and the expected PC stream.
module tb_if_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instruction;

  if_fetch_unit #(
    .RESET_PC        (TB_RESET_PC),
    .NOP_INSTRUCTION (TB_NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus_4    (if_pc_plus_4),
    .if_instruction  (if_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_next_pc;
  int          m_occ;
  int          num_vectors;
  int          num_miscompares;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  function automatic logic [31:0] random_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic check_idle_outputs(input string phase);
    checkOutput({phase, " if_pc"}, if_pc, 32'h0);
    checkOutput({phase, " if_pc_plus_4"}, if_pc_plus_4, 32'h0);
    checkOutput({phase, " if_instruction"}, if_instruction, TB_NOP);
  endtask

  // Holds reset for a number of cycles; the memory forgets in-flight requests too.
  task automatic apply_reset(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      rst             = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      redirect_valid  = 1'($urandom_range(0, 1));
      redirect_pc     = $urandom;
      id_ready        = 1'b1;
      @(negedge clk);
      checkOutput("rst imem_req_valid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("rst if_valid", {31'b0, if_valid}, 32'h0);
      check_idle_outputs("rst");
    end
    mem_q.delete();
    m_occ      = 0;
    m_fetch_pc = TB_RESET_PC;
    m_next_pc  = TB_RESET_PC;
  endtask

  // One clock of stimulus followed by checks against the model and a model update.
  task automatic applyStimulus(input int ready_pct, input int resp_pct, input int idr_pct,
                               input int redir_pct, input bit force_redir,
                               input logic [31:0] target);
    int stale_cnt;
    bit exp_req;
    bit exp_valid;
    bit resp_stale;
    @(posedge clk); #1;
    rst            = 1'b0;
    imem_req_ready = chance(ready_pct);
    id_ready       = chance(idr_pct);
    redirect_valid = force_redir || chance(redir_pct);
    redirect_pc    = force_redir ? target : random_target();
    if (mem_q.size() > 0 && chance(resp_pct)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);

    stale_cnt = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_cnt++;
    exp_req   = !redirect_valid && (stale_cnt == 0) && (mem_q.size() + m_occ < 2);
    exp_valid = (m_occ > 0);

    checkOutput("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    checkOutput("imem_addr", imem_addr, m_fetch_pc);
    checkOutput("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      checkOutput("if_pc", if_pc, m_next_pc);
      checkOutput("if_pc_plus_4", if_pc_plus_4, m_next_pc + 32'd4);
      checkOutput("if_instruction", if_instruction, instr_of(m_next_pc));
    end else begin
      check_idle_outputs("idle");
    end

    resp_stale = 1'b1;
    if (imem_resp_valid) begin
      resp_stale = mem_q[0].stale;
      void'(mem_q.pop_front());
    end
    if (redirect_valid) begin
      m_occ = 0;
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      m_next_pc  = m_fetch_pc;
    end else begin
      if (imem_resp_valid && !resp_stale) m_occ++;
      if (exp_valid && id_ready) begin
        m_occ--;
        m_next_pc = m_next_pc + 32'd4;
      end
      if (exp_req && imem_req_ready) begin
        mem_q.push_back('{addr: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  initial begin
    int rdy, rsp, idr;
    num_vectors     = 0;
    num_miscompares = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    id_ready        = 1'b0;

    apply_reset(2);

    // Streaming from reset, then a consumer stall.
    repeat (12) applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);
    repeat (5)  applyStimulus(100, 100, 0, 0, 1'b0, 32'h0);
    repeat (6)  applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);

    // Redirect to an unaligned target with two requests in flight.
    repeat (5)  applyStimulus(100, 0, 100, 0, 1'b0, 32'h0);
    applyStimulus(100, 0, 100, 0, 1'b1, 32'h0000_0103);
    repeat (10) applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);

    // Second redirect while still draining stale responses.
    repeat (5)  applyStimulus(100, 0, 100, 0, 1'b0, 32'h0);
    applyStimulus(100, 0, 100, 0, 1'b1, 32'h0000_0103);
    applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);
    applyStimulus(100, 0, 100, 0, 1'b1, 32'h0000_0200);
    repeat (10) applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);

    // Address wrap at the top of the 32-bit space.
    applyStimulus(100, 100, 100, 0, 1'b1, 32'hFFFF_FFF8);
    repeat (12) applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);

    // Reset in the middle of a stream with a full buffer.
    repeat (6)  applyStimulus(100, 100, 0, 0, 1'b0, 32'h0);
    apply_reset(1);
    repeat (4)  applyStimulus(100, 100, 100, 0, 1'b0, 32'h0);

    // Random traffic in segments with varying handshake pressure.
    repeat (60) begin
      rdy = int'($urandom_range(20, 100));
      rsp = int'($urandom_range(20, 100));
      idr = int'($urandom_range(20, 100));
      repeat (50) applyStimulus(rdy, rsp, idr, 6, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTRUCTION, default 32'h0000_0013, meaning the instruction driven when no instruction is valid.
REQ-003 SHALL use one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_resp_valid  input  1  response data valid; responses return in order, at least 1 cycle after acceptance.
REQ-010 imem_resp_data  input  32  fetched instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect (same event that flushes IF/ID).
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 id_ready  input  1  IF/ID register enabled (not stalled).
REQ-014 if_valid  output  1  if_pc/if_pc_plus_4/if_instruction valid.
REQ-015 if_pc  output  32  PC of the presented instruction.
REQ-016 if_pc_plus_4  output  32  if_pc + 4, modulo 2^32.
REQ-017 if_instruction  output  32  presented instruction word.

Function
REQ-018 SHALL hold fetch_pc (next request address), resp_pc (PC of next accepted response), outstanding count (0..2), a 2-entry {pc, instr} buffer, and FSM state RUN or DRAIN.
REQ-019 imem_req_valid SHALL be 1 only when state=RUN, rst=0, redirect_valid=0, and outstanding + buffer occupancy < 2 (registered values).
REQ-020 imem_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 on each accepted request (valid & ready), wrapping modulo 2^32.
REQ-021 In RUN, each imem_resp_valid SHALL push {resp_pc, imem_resp_data} into the buffer, advance resp_pc by 4, and decrement outstanding.
REQ-022 Request acceptance and response in the same cycle SHALL leave outstanding unchanged.
REQ-023 if_valid SHALL be 1 when the buffer is non-empty; the head SHALL pop when if_valid & id_ready; a push and pop in the same cycle SHALL both take effect.
REQ-024 When if_valid=0, if_pc and if_pc_plus_4 SHALL be 0 and if_instruction SHALL be NOP_INSTRUCTION.
REQ-025 Latency: a response arriving in cycle N SHALL appear on the if_* outputs in cycle N+1 if the buffer was empty.
REQ-026 redirect_valid SHALL have priority over all other events: clear the buffer, load fetch_pc and resp_pc with {redirect_pc[31:2],2'b00}, and set the drop count to the number of in-flight responses after this cycle.
REQ-027 A response arriving in the redirect cycle SHALL be discarded and SHALL NOT count toward the drop count.
REQ-028 Transition RUN->DRAIN SHALL occur on redirect with drop count > 0; on redirect with drop count = 0, state SHALL stay RUN.
REQ-029 In DRAIN, no request SHALL issue, each response SHALL be discarded and decrement the drop count, and state SHALL return to RUN when the count reaches 0.
REQ-030 A redirect while in DRAIN SHALL overwrite the target, keep the remaining drop count, and stay in DRAIN.
REQ-031 if_valid SHALL be 0 in the cycle after any redirect.

Reset
REQ-032 On rst=1 at a clock edge: fetch_pc=resp_pc=RESET_PC, outstanding=0, drop count=0, buffer empty, state=RUN.
REQ-033 While rst=1: imem_req_valid=0, if_valid=0, if_pc=0, if_pc_plus_4=0, if_instruction=NOP_INSTRUCTION.
REQ-034 Responses to requests issued before a mid-operation reset are the memory's responsibility; the memory interface SHALL be reset in the same cycle.

Structure
REQ-035 The shared pipeline package SHALL hold NOP_INSTRUCTION, RESET_PC default, and the RUN/DRAIN state encoding.
REQ-036 The 2-entry buffer SHALL be a sub-module fetch_buffer (push, pop, flush, full, empty, 64-bit entry).

Verification
REQ-037 Reset release, imem_req_ready=1, responses at 1-cycle latency, id_ready=1 -> addresses 0,4,8,...; if_pc sequence 0,4,8 with matching instructions and no bubbles.
REQ-038 id_ready=0 for 5 cycles -> at most 2 outstanding + buffered; no request beyond credit; no instruction lost or duplicated.
REQ-039 Redirect to 32'h0000_0103 with 2 outstanding -> 2 responses dropped; next request address 0x100; first if_pc = 0x100.
REQ-040 Second redirect to 0x200 during DRAIN -> remaining stale responses dropped; fetch resumes at 0x200.
REQ-041 fetch_pc = 0xFFFF_FFFC -> next address 0x0000_0000; if_pc_plus_4 = 0.
REQ-042 rst asserted mid-stream with a full buffer -> next cycle if_valid=0, if_instruction=0x0000_0013, imem_addr=RESET_PC.
